// File: rtl/serial_tx_controller.sv
// Serial frame receiver/transmit sequencer: captures a start bit and a CNT_W-bit count,
// loads an external down-counter, then gates the payload driver until the counter hits zero.
module serial_tx_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  input  logic             Cout,
  output logic [CNT_W-1:0] parOut,
  output logic             ld_counter,
  output logic             dec_counter,
  output logic             tri_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  typedef enum logic [2:0] {StIdle, StRecv, StLoad, StTx, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    ld_counter  = 1'b0;
    dec_counter = 1'b0;
    tri_en      = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy  = 1'b0;
        idx_d = '0;
        if (!serIn) state_d = StRecv;
      end
      StRecv: begin
        // MSB arrives first, so each new bit enters at the LSB end
        shift_d = (shift_q << 1) | CNT_W'(serIn);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IdxW'(CNT_W - 1)) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        ld_counter = 1'b1;
        state_d    = StTx;
      end
      StTx: begin
        tri_en      = ~Cout;
        dec_counter = ~Cout;
        if (Cout) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign parOut = shift_q;

endmodule

// File: tb/tb_serial_tx_controller.sv
// Randomized frame bench with a down-counter model; expected output timelines are derived
// from frame arithmetic (8 count bits, one load cycle, N payload cycles, one exit cycle, done).
module tb_serial_tx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b1;
  logic       Cout;
  logic [7:0] parOut;
  logic       ld_counter, dec_counter, tri_en, busy, done;
  logic [7:0] cnt_model = 8'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream counter the block controls
  assign Cout = (cnt_model == 8'd0);
  always @(posedge clk) begin
    if (ld_counter === 1'b1) cnt_model <= parOut;
    else if (dec_counter === 1'b1) cnt_model <= cnt_model - 8'd1;
  end

  serial_tx_controller #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .serIn      (serIn),
    .Cout       (Cout),
    .parOut     (parOut),
    .ld_counter (ld_counter),
    .dec_counter(dec_counter),
    .tri_en     (tri_en),
    .busy       (busy),
    .done       (done)
  );

  // Drives one frame with count n; abort_at >= 0 pulses rst on that edge index (edge 0 = start bit).
  task automatic frame(input int n, input int abort_at, input string tag);
    bit         vals [0:300];
    int         last = 11 + n;
    int         tri_cnt = 0, dec_cnt = 0, done_cnt = 0, pay_obs = 0, pay_exp = 0;
    logic [4:0] exp_v;
    logic [7:0] nb = 8'(n);
    for (int t = 0; t <= last + 1; t++) vals[t] = ($urandom_range(0, 1) == 1);
    vals[0] = 1'b0;
    for (int i = 1; i <= 8; i++) vals[i] = nb[8-i];
    // Payload present on the line during TX cycles 9..8+n is driven before edges 10..9+n
    for (int t = 10; t <= 9 + n; t++) pay_exp += int'(vals[t]);
    for (int t = 0; t <= last; t++) begin
      serIn = vals[t];
      rst   = (t == abort_at);
      @(posedge clk);
      @(negedge clk);
      if (t == abort_at) begin
        rst   = 1'b0;
        serIn = 1'b1;
        checks++;
        if ({busy, ld_counter, dec_counter, tri_en, done} !== 5'b0 || parOut !== 8'h00) begin
          errors++;
          $display("FAIL %s abort@%0d: busy/ld/dec/tri/done=%b parOut=%h, required 00000 00",
                   tag, t, {busy, ld_counter, dec_counter, tri_en, done}, parOut);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, tri_en, done} !== 3'b0) begin
          errors++;
          $display("FAIL %s post-abort idle: busy/tri/done=%b, required 000", tag,
                   {busy, tri_en, done});
        end
        return;
      end
      exp_v = {(t == 8), (t >= 9 && t <= 8 + n), (t >= 9 && t <= 8 + n), (t <= 10 + n),
               (t == 10 + n)};
      checks++;
      if ({ld_counter, dec_counter, tri_en, busy, done} !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: ld/dec/tri/busy/done=%b, required %b", tag, t,
                 {ld_counter, dec_counter, tri_en, busy, done}, exp_v);
      end
      if (t >= 8) begin
        checks++;
        if (parOut !== nb) begin
          errors++;
          $display("FAIL %s parOut cycle %0d: got %h, required %h", tag, t, parOut, nb);
        end
      end
      if (tri_en === 1'b1) begin
        tri_cnt++;
        pay_obs += int'(vals[t+1]);
      end
      if (dec_counter === 1'b1) dec_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (tri_cnt != n || dec_cnt != n) begin
      errors++;
      $display("FAIL %s tri/dec cycles: got %0d/%0d, required %0d", tag, tri_cnt, dec_cnt, n);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d, required 1", tag, done_cnt);
    end
    checks++;
    if (pay_obs != pay_exp) begin
      errors++;
      $display("FAIL %s payload ones passed: got %0d, required %0d", tag, pay_obs, pay_exp);
    end
  endtask

  task automatic idle_cycles(input int k);
    serIn = 1'b1;
    rst   = 1'b0;
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    serIn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({busy, ld_counter, dec_counter, tri_en, done} !== 5'b0 || parOut !== 8'h00) begin
        errors++;
        $display("FAIL reset idle %0d: busy/ld/dec/tri/done=%b parOut=%h, required 00000 00",
                 i, {busy, ld_counter, dec_counter, tri_en, done}, parOut);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_count3();
    frame(3, -1, "count3");
    idle_cycles(3);
  endtask

  task automatic test_count0();
    frame(0, -1, "count0");
    idle_cycles(3);
  endtask

  task automatic test_count255();
    frame(255, -1, "count255");
    idle_cycles(3);
  endtask

  task automatic test_reset_abort();
    frame(8'h5a, 5, "abort_recv");
    idle_cycles(2);
    frame(16, 12, "abort_tx");
    idle_cycles(2);
    frame(2, -1, "after_abort");
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    frame(1, -1, "b2b_first");
    frame(2, -1, "b2b_second");
    idle_cycles(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      frame(int'($urandom_range(0, 40)), -1, "random");
      idle_cycles(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_count3();
    test_count0();
    test_count255();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
